serial_frame_deserializer: RTL and testbench
============================================

// Module: serial_frame_deserializer
// PURPOSE
//  Receive end of the team's 6-bit shift-register link: takes a framed serial bit stream
//  (start bit 0, WIDTH data bits, stop bit 1) and returns a parallel word to downstream logic.
//  Downstream logic consumes the word through a valid/ready handshake.
//  Sits after the link's bit-timing logic (supplies bit_en) and before any parallel consumer.
// PARAMETERS
//  WIDTH      6   data bits per frame (>=2)
//  MSB_FIRST  1   1: first data bit received -> par_out[WIDTH-1]; 0: first bit -> par_out[0]
// PORTS
//  clk        in   1      single clock; all logic on posedge clk
//  rst_n      in   1      synchronous, active-low reset
//  bit_en     in   1      sample strobe; ser_in is sampled only on cycles with bit_en=1
//  ser_in     in   1      serial line, idle high
//  par_out    out  WIDTH  received word, held stable while par_valid=1 and not accepted
//  par_valid  out  1      par_out holds an unconsumed word
//  par_ready  in   1      consumer accepts word when par_valid & par_ready
//  frame_err  out  1      one-cycle pulse: stop bit sampled as 0
//  overrun    out  1      sticky: completed frame dropped because par_valid=1 and not accepted
//  ovr_clr    in   1      clears overrun (overrun set in same cycle takes priority)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, bit count=0, shift reg=0, par_out=0, par_valid=0,
//   frame_err=0, overrun=0. Reset mid-frame discards the partial frame; no error is flagged.
//  Cycles with bit_en=0: FSM, counter and shift register hold. frame_err=0.
//  FSM, advancing only on bit_en=1:
//   IDLE : ser_in=0 -> DATA, cnt=0. ser_in=1 -> stay in IDLE.
//   DATA : shift ser_in into the shift reg (left if MSB_FIRST, else right), cnt++.
//          After the WIDTH-th bit -> STOP.
//   STOP : ser_in=1 -> commit the word, go to IDLE.
//          ser_in=0 -> frame_err=1 for one cycle, discard the word, go to IDLE.
//          No start search is made in this same cycle.
//  Commit: par_out/par_valid update on the posedge that samples the stop bit.
//   par_valid is visible the next cycle, WIDTH+2 bit_en strobes after the start bit.
//   if par_valid=0, or par_valid&par_ready this cycle: par_out<=word, par_valid<=1.
//    Back-to-back handoff; no overrun.
//   else: word dropped, par_out unchanged, overrun<=1.
//  Handshake: par_valid&par_ready with no commit -> par_valid<=0; par_out holds its last value.
//   par_valid never drops without acceptance; par_out never changes while valid and unaccepted.
//  overrun: set per the commit rule; cleared by ovr_clr=1 only when no set occurs in that cycle.
//  Consecutive frames may abut: a start bit in the strobe right after the stop bit is accepted.
// STRUCTURE
//  Shared include serdes_defs.vh: state encodings ST_IDLE=2'd0, ST_DATA=2'd1, ST_STOP=2'd2.
//   The transmit side of the link reuses the same file.
//  Sub-module sipo_shift_reg #(WIDTH, MSB_FIRST)
//   (clk, rst_n, shift_en, din, q): serial-in/parallel-out register.
//   Instantiated once. The FSM, counter and output/handshake register stay in the top module.
//  Counter width: $clog2(WIDTH+1). State register: 2 bits. Encoding 2'd3 recovers to IDLE.
// TESTING
//  1 Reset: rst_n=0 two cycles with toggling inputs -> par_out=0, par_valid=0, frame_err=0, overrun=0.
//  2 MSB_FIRST=1, bit_en every cycle, par_ready=1, send 0,1,0,1,1,0,1,1
//    -> par_out=6'b101101, par_valid high exactly 1 cycle.
//  3 Same frame with bit_en every 4th cycle, par_ready=0 -> par_valid stays 1 and par_out stable
//    until ready is raised; it clears the cycle after acceptance.
//  4 Stop bit 0 (frame 0,111111,0) -> frame_err single pulse, par_valid stays 0, FSM back in IDLE.
//    The next good frame 0,000111,1 -> par_out=6'b000111.
//  5 par_ready=0, two good frames 6'h2A then 6'h15 -> par_out=6'h2A, overrun=1 after the second stop bit.
//    ovr_clr clears it. A repeat with par_ready=1 on the commit cycle -> par_out=6'h15, no overrun.
//  6 rst_n=0 after 3 data bits, then full frame 6'h3C -> par_out=6'h3C, no frame_err.
//    MSB_FIRST=0 run of 2 -> par_out=6'b110110.

Source files
------------

// File: rtl/serial_frame_deserializer_pkg.sv
// Shared definitions for the serial frame deserializer: FSM state encoding
// (shared with the transmit side of the link) and default frame geometry.
package serial_frame_deserializer_pkg;

    localparam int DEF_WIDTH     = 6;
    localparam bit DEF_MSB_FIRST = 1'b1;

    // Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage

// File: rtl/serial_frame_deserializer_if.sv
// Serial input plus parallel valid/ready output bundle of the deserializer.
// slave = the deserializer itself, master = the side driving the line and consuming words.
interface serial_frame_deserializer_if #(
    parameter int WIDTH = 6
);
    logic             bit_en;
    logic             ser_in;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             par_ready;
    logic             frame_err;
    logic             overrun;
    logic             ovr_clr;

    modport slave (
        input  bit_en, ser_in, par_ready, ovr_clr,
        output par_out, par_valid, frame_err, overrun
    );

    modport master (
        output bit_en, ser_in, par_ready, ovr_clr,
        input  par_out, par_valid, frame_err, overrun
    );
endinterface

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out register. With MSB_FIRST the first bit shifted in
// ends up in q[WIDTH-1]; otherwise it ends up in q[0].
module sipo_shift_reg #(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Shift one bit per enabled cycle in the configured direction.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every flop samples pre-edge values;
        // a blocking = here would make simulation order-dependent.
        if (!rst_n) begin
            q <= '0;
        end else if (shift_en) begin
            if (MSB_FIRST) q <= {q[WIDTH-2:0], din};
            else           q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Receive side of the 6-bit shift-register link: hunts for a start bit,
// collects WIDTH data bits, checks the stop bit and hands the word to a
// valid/ready consumer. Everything advances only on bit_en strobes.
module serial_frame_deserializer
    import serial_frame_deserializer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
    input logic                       clk,
    input logic                       rst_n,
    serial_frame_deserializer_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             shift_en;
    logic             commit;
    logic             bad_stop;
    logic             ovr_set;
    logic [WIDTH-1:0] word;

    sipo_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sipo (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_en(shift_en),
        .din     (bus.ser_in),
        .q       (word)
    );

    // State and bit-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter and per-strobe control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_en  = 1'b0;
        commit    = 1'b0;
        bad_stop  = 1'b0;
        if (bus.bit_en) begin
            case (state)
                ST_IDLE: begin
                    if (!bus.ser_in) begin
                        state_nxt = ST_DATA;
                        cnt_nxt   = '0;
                    end
                end
                ST_DATA: begin
                    shift_en = 1'b1;
                    cnt_nxt  = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    // The stop-bit strobe is never also treated as a start bit.
                    if (bus.ser_in) commit   = 1'b1;
                    else            bad_stop = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // A finished word is lost only if the previous one is still held and not taken now.
    assign ovr_set = commit && bus.par_valid && !bus.par_ready;

    // Output word, handshake, error pulse and sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.par_out   <= '0;
            bus.par_valid <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.frame_err <= bad_stop;
            if (commit && !ovr_set) begin
                bus.par_out   <= word;
                bus.par_valid <= 1'b1;
            end else if (bus.par_valid && bus.par_ready) begin
                bus.par_valid <= 1'b0;
            end
            if (ovr_set)          bus.overrun <= 1'b1;
            else if (bus.ovr_clr) bus.overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer: one MSB-first and one
// LSB-first instance, each scenario in its own task with inline checks.
module tb_serial_frame_deserializer;
    import serial_frame_deserializer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    serial_frame_deserializer_if #(.WIDTH(6)) bus_m ();
    serial_frame_deserializer_if #(.WIDTH(6)) bus_l ();

    serial_frame_deserializer #(.WIDTH(6), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus(bus_m)
    );
    serial_frame_deserializer #(.WIDTH(6), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(bus_l)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // Drive one strobed bit on the selected instance (0 = MSB-first, 1 = LSB-first),
    // then gap idle cycles with bit_en low and the line idle high.
    task automatic send_bit(input int which, input logic b, input int gap);
        if (which == 0) begin bus_m.bit_en = 1'b1; bus_m.ser_in = b; end
        else            begin bus_l.bit_en = 1'b1; bus_l.ser_in = b; end
        tick();
        bus_m.bit_en = 1'b0; bus_m.ser_in = 1'b1;
        bus_l.bit_en = 1'b0; bus_l.ser_in = 1'b1;
        repeat (gap) tick();
    endtask

    // Start bit plus six data bits sent d[5] first; the stop bit is sent separately.
    task automatic send_body(input int which, input logic [5:0] d, input int gap);
        send_bit(which, 1'b0, gap);
        for (int i = 5; i >= 0; i--) send_bit(which, d[i], gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_m.bit_en = i[0]; bus_m.ser_in = i[0]; bus_m.par_ready = ~i[0]; bus_m.ovr_clr = i[0];
            tick();
        end
        bus_m.bit_en = 1'b0; bus_m.ser_in = 1'b1; bus_m.par_ready = 1'b0; bus_m.ovr_clr = 1'b0;
        chk("reset_par_out",   {2'b0, bus_m.par_out}, 8'h00);
        chk("reset_par_valid", {7'b0, bus_m.par_valid}, 8'h00);
        chk("reset_frame_err", {7'b0, bus_m.frame_err}, 8'h00);
        chk("reset_overrun",   {7'b0, bus_m.overrun}, 8'h00);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus_m.par_ready = 1'b1;
        send_body(0, 6'b101101, 0);
        chk("basic_valid_before_stop", {7'b0, bus_m.par_valid}, 8'h00);
        send_bit(0, 1'b1, 0);
        chk("basic_valid", {7'b0, bus_m.par_valid}, 8'h01);
        chk("basic_par_out", {2'b0, bus_m.par_out}, 8'h2D);
        tick();
        chk("basic_valid_one_cycle", {7'b0, bus_m.par_valid}, 8'h00);
    endtask

    task automatic test_slow_strobe();
        bus_m.par_ready = 1'b0;
        send_body(0, 6'b101101, 3);
        send_bit(0, 1'b1, 0);
        chk("slow_valid", {7'b0, bus_m.par_valid}, 8'h01);
        chk("slow_par_out", {2'b0, bus_m.par_out}, 8'h2D);
        repeat (6) tick();
        chk("slow_valid_held", {7'b0, bus_m.par_valid}, 8'h01);
        chk("slow_par_out_held", {2'b0, bus_m.par_out}, 8'h2D);
        bus_m.par_ready = 1'b1;
        tick();
        chk("slow_valid_cleared", {7'b0, bus_m.par_valid}, 8'h00);
        chk("slow_par_out_kept", {2'b0, bus_m.par_out}, 8'h2D);
    endtask

    task automatic test_frame_err();
        bus_m.par_ready = 1'b1;
        send_body(0, 6'b111111, 0);
        send_bit(0, 1'b0, 0);
        chk("ferr_pulse", {7'b0, bus_m.frame_err}, 8'h01);
        chk("ferr_valid", {7'b0, bus_m.par_valid}, 8'h00);
        tick();
        chk("ferr_pulse_end", {7'b0, bus_m.frame_err}, 8'h00);
        send_body(0, 6'b000111, 0);
        send_bit(0, 1'b1, 0);
        chk("ferr_next_valid", {7'b0, bus_m.par_valid}, 8'h01);
        chk("ferr_next_par_out", {2'b0, bus_m.par_out}, 8'h07);
        tick();
    endtask

    task automatic test_overrun();
        bus_m.par_ready = 1'b0;
        send_body(0, 6'h2A, 0);
        send_bit(0, 1'b1, 0);
        chk("ovr_first_par_out", {2'b0, bus_m.par_out}, 8'h2A);
        chk("ovr_first_overrun", {7'b0, bus_m.overrun}, 8'h00);
        send_body(0, 6'h15, 0);
        send_bit(0, 1'b1, 0);
        chk("ovr_set", {7'b0, bus_m.overrun}, 8'h01);
        chk("ovr_par_out_kept", {2'b0, bus_m.par_out}, 8'h2A);
        chk("ovr_valid_kept", {7'b0, bus_m.par_valid}, 8'h01);
        bus_m.ovr_clr = 1'b1;
        tick();
        bus_m.ovr_clr = 1'b0;
        chk("ovr_cleared", {7'b0, bus_m.overrun}, 8'h00);
        send_body(0, 6'h15, 0);
        bus_m.par_ready = 1'b1;
        send_bit(0, 1'b1, 0);
        chk("ovr_handoff_par_out", {2'b0, bus_m.par_out}, 8'h15);
        chk("ovr_handoff_valid", {7'b0, bus_m.par_valid}, 8'h01);
        chk("ovr_handoff_no_overrun", {7'b0, bus_m.overrun}, 8'h00);
        tick();
        chk("ovr_handoff_drained", {7'b0, bus_m.par_valid}, 8'h00);
    endtask

    task automatic test_mid_reset();
        bus_m.par_ready = 1'b1;
        send_bit(0, 1'b0, 0);
        send_bit(0, 1'b1, 0);
        send_bit(0, 1'b0, 0);
        send_bit(0, 1'b1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mreset_valid", {7'b0, bus_m.par_valid}, 8'h00);
        chk("mreset_frame_err", {7'b0, bus_m.frame_err}, 8'h00);
        send_body(0, 6'h3C, 0);
        send_bit(0, 1'b1, 0);
        chk("mreset_par_out", {2'b0, bus_m.par_out}, 8'h3C);
        chk("mreset_no_err", {7'b0, bus_m.frame_err}, 8'h00);
        tick();
    endtask

    task automatic test_lsb_first();
        bus_l.par_ready = 1'b1;
        send_body(1, 6'b011011, 0);
        send_bit(1, 1'b1, 0);
        chk("lsb_valid", {7'b0, bus_l.par_valid}, 8'h01);
        chk("lsb_par_out", {2'b0, bus_l.par_out}, 8'h36);
    endtask

    initial begin
        bus_m.bit_en = 1'b0; bus_m.ser_in = 1'b1; bus_m.par_ready = 1'b0; bus_m.ovr_clr = 1'b0;
        bus_l.bit_en = 1'b0; bus_l.ser_in = 1'b1; bus_l.par_ready = 1'b0; bus_l.ovr_clr = 1'b0;
        test_reset();
        test_basic();
        test_slow_strobe();
        test_frame_err();
        test_overrun();
        test_mid_reset();
        test_lsb_first();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
